// File: rtl/histogram_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_accumulator_if
//  Brief    : Pixel stream, display read port and status of the histogram block
//  Revision : 1.0
// ============================================================================
interface histogram_accumulator_if #(
    parameter int CNT_W  = 20,
    parameter int DROP_W = 16
);
    logic [7:0]        pixel;
    logic              pixel_valid;
    logic              frame_start;
    logic              frame_end;
    logic [7:0]        rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic              bank_sel;
    logic              frame_done;
    logic              busy;
    logic [CNT_W-1:0]  peak_value;
    logic [7:0]        peak_bin;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output pixel, pixel_valid, frame_start, frame_end, rd_addr,
        input  rd_data, bank_sel, frame_done, busy, peak_value, peak_bin, drop_count
    );

    modport slave (
        input  pixel, pixel_valid, frame_start, frame_end, rd_addr,
        output rd_data, bank_sel, frame_done, busy, peak_value, peak_bin, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/histogram_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_accumulator
//  Brief    : Ping-pong 256-bin histogram with RMW pipeline and peak tracking
//  Revision : 1.0
// ============================================================================
module histogram_accumulator #(
    parameter int CNT_W  = 20,
    parameter int BINS   = 256,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    histogram_accumulator_if.slave bus
);
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_SWAP  = 3'd4;
    localparam logic [2:0] S_CLEAR = 3'd5;

    localparam logic [7:0]        LAST_ADDR = 8'(BINS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;

    logic [2:0]        state, state_nx;
    logic [7:0]        sweep;
    logic              pending;
    logic              bank_sel;
    logic              busy, frame_done, accept, drop, init_wr, clear_wr;

    logic [CNT_W-1:0]  mem0 [BINS];
    logic [CNT_W-1:0]  mem1 [BINS];

    logic              s1_valid, s2_valid, s3_valid;
    logic [7:0]        s1_bin, s2_bin, s3_bin;
    logic [CNT_W-1:0]  s1_rdata, s2_value, s3_value;
    logic [CNT_W-1:0]  base, incr;

    logic              wr_en, we0, we1;
    logic [7:0]        wr_addr;
    logic [CNT_W-1:0]  wr_data;

    logic [CNT_W-1:0]  run_val, peak_value, rd_data;
    logic [7:0]        run_bin, peak_bin;
    logic [DROP_W-1:0] drop_count;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:  if (sweep == LAST_ADDR) state_nx = S_IDLE;
            S_IDLE:  if (bus.frame_start)    state_nx = S_ACCUM;
            S_ACCUM: if (bus.frame_end)      state_nx = S_FLUSH;
            S_FLUSH: if (sweep == 8'd1)      state_nx = S_SWAP;
            S_SWAP:  state_nx = S_CLEAR;
            S_CLEAR: if (sweep == LAST_ADDR)
                         state_nx = (pending || bus.frame_start) ? S_ACCUM : S_IDLE;
            default: state_nx = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        accept     = 1'b0;
        init_wr    = 1'b0;
        clear_wr   = 1'b0;
        case (state)
            S_INIT:  begin busy = 1'b1; init_wr = 1'b1; end
            S_IDLE:  accept = bus.pixel_valid && bus.frame_start;
            S_ACCUM: accept = bus.pixel_valid;
            S_FLUSH: busy = 1'b1;
            S_SWAP:  begin busy = 1'b1; frame_done = 1'b1; end
            S_CLEAR: begin busy = 1'b1; clear_wr = 1'b1; end
            default: busy = 1'b1;
        endcase
    end

    assign drop = bus.pixel_valid && !accept;

    // Sweep restarts on every state change; doubles as the FLUSH cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sweep <= 8'd0;
        else if (state_nx != state) sweep <= 8'd0;
        else                        sweep <= sweep + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= 1'b0;
        else if (state == S_CLEAR && sweep == LAST_ADDR)
            pending <= 1'b0;
        else if (bus.frame_start &&
                 (state == S_FLUSH || state == S_SWAP || state == S_CLEAR ||
                  (state == S_ACCUM && bus.frame_end)))
            pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                bank_sel <= 1'b0;
        else if (state == S_SWAP)  bank_sel <= ~bank_sel;
    end

    // ---------------- RMW pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_bin   <= 8'd0;
            s2_bin   <= 8'd0;
            s3_bin   <= 8'd0;
            s2_value <= '0;
            s3_value <= '0;
        end else begin
            s1_valid <= accept;
            s1_bin   <= bus.pixel;
            s2_valid <= s1_valid;
            s2_bin   <= s1_bin;
            s2_value <= incr;
            s3_valid <= s2_valid;
            s3_bin   <= s2_bin;
            s3_value <= s2_value;
        end
    end

    // s3 covers the read that collided with a write-back on the same edge
    always_comb begin
        if (s2_valid && s2_bin == s1_bin)      base = s2_value;
        else if (s3_valid && s3_bin == s1_bin) base = s3_value;
        else                                   base = s1_rdata;
        incr = (base == CNT_MAX) ? CNT_MAX : base + CNT_W'(1);
    end

    // ---------------- Bank memories ----------------
    assign wr_en   = clear_wr || s2_valid;
    assign we0     = init_wr || (wr_en && bank_sel);
    assign we1     = init_wr || (wr_en && !bank_sel);
    assign wr_addr = (init_wr || clear_wr) ? sweep : s2_bin;
    assign wr_data = (init_wr || clear_wr) ? '0 : s2_value;

    always_ff @(posedge clk) begin
        if (we0) mem0[wr_addr] <= wr_data;
        if (we1) mem1[wr_addr] <= wr_data;
        s1_rdata <= bank_sel ? mem0[bus.pixel] : mem1[bus.pixel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               rd_data <= '0;
        else if (state == S_INIT) rd_data <= '0;
        else                      rd_data <= bank_sel ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
    end

    // ---------------- Peak tracking ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_val    <= '0;
            run_bin    <= 8'd0;
            peak_value <= '0;
            peak_bin   <= 8'd0;
        end else if (state == S_SWAP) begin
            peak_value <= run_val;
            peak_bin   <= run_bin;
            run_val    <= '0;
            run_bin    <= 8'd0;
        end else if (s2_valid && (s2_value > run_val ||
                                  (s2_value == run_val && s2_bin < run_bin))) begin
            run_val <= s2_value;
            run_bin <= s2_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            drop_count <= '0;
        else if (drop && drop_count != DROP_MAX) drop_count <= drop_count + DROP_W'(1);
    end

    assign bus.rd_data    = rd_data;
    assign bus.bank_sel   = bank_sel;
    assign bus.frame_done = frame_done;
    assign bus.busy       = busy;
    assign bus.peak_value = peak_value;
    assign bus.peak_bin   = peak_bin;
    assign bus.drop_count = drop_count;
endmodule
`default_nettype wire

// File: tb/tb_histogram_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histogram_accumulator
//  Brief    : Randomised frames checked against a per-frame bin-count model
//  Revision : 1.0
// ============================================================================
module tb_histogram_accumulator;
    localparam int CW   = 12;
    localparam int DW   = 5;
    localparam int CMAX = (1 << CW) - 1;
    localparam int DMAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    histogram_accumulator_if #(.CNT_W(CW), .DROP_W(DW)) bus ();

    histogram_accumulator #(.CNT_W(CW), .BINS(256), .DROP_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc  [256];
    int   disp [256];
    int   drop_ref;
    logic bank_ref;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
    endtask

    task automatic gap(input int n);
        idle_inputs();
        repeat (n) tick();
    endtask

    // One input cycle; 'counted' states whether the frame rules say this pixel lands in a bin
    task automatic px(input bit v, input int p, input bit fs, input bit fe, input bit counted);
        bus.pixel_valid = v;
        bus.pixel       = p[7:0];
        bus.frame_start = fs;
        bus.frame_end   = fe;
        tick();
        idle_inputs();
        if (v) begin
            if (counted) acc[p[7:0]] = (acc[p[7:0]] < CMAX) ? acc[p[7:0]] + 1 : CMAX;
            else         drop_ref    = (drop_ref < DMAX) ? drop_ref + 1 : DMAX;
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 256; b++) begin
            acc[b]  = 0;
            disp[b] = 0;
        end
        drop_ref = 0;
        bank_ref = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy && k < 2000) begin
            tick();
            k++;
        end
        check_value({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 256; a++) begin
            bus.rd_addr = a[7:0];
            tick();
            check_value($sformatf("%s bin%0d", tag, a), 32'(bus.rd_data), disp[a]);
        end
    endtask

    task automatic finish_frame(input int probe);
        int k = 0;
        int pv, pb;
        bus.rd_addr = probe[7:0];
        while (!bus.frame_done && k < 50) begin
            tick();
            k++;
        end
        check_value("frame_done", {31'd0, bus.frame_done}, 32'd1);
        check_value("bank before swap", {31'd0, bus.bank_sel}, {31'd0, bank_ref});
        tick();
        check_value("read in swap cycle", 32'(bus.rd_data), disp[probe]);
        check_value("frame_done width", {31'd0, bus.frame_done}, 32'd0);
        disp     = acc;
        bank_ref = ~bank_ref;
        pv = 0;
        pb = 0;
        for (int b = 0; b < 256; b++) begin
            acc[b] = 0;
            if (disp[b] > pv) begin
                pv = disp[b];
                pb = b;
            end
        end
        check_value("bank after swap", {31'd0, bus.bank_sel}, {31'd0, bank_ref});
        check_value("peak value", 32'(bus.peak_value), pv);
        check_value("peak bin", 32'(bus.peak_bin), pb);
        check_value("drop count", 32'(bus.drop_count), drop_ref);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, " busy"},  {31'd0, bus.busy}, 32'd1);
        check_value({tag, " bank"},  {31'd0, bus.bank_sel}, 32'd0);
        check_value({tag, " done"},  {31'd0, bus.frame_done}, 32'd0);
        check_value({tag, " peakv"}, 32'(bus.peak_value), 32'd0);
        check_value({tag, " peakb"}, 32'(bus.peak_bin), 32'd0);
        check_value({tag, " drops"}, 32'(bus.drop_count), 32'd0);
        check_value({tag, " rdata"}, 32'(bus.rd_data), 32'd0);
    endtask

    task automatic random_frame(input int npix);
        int p;
        for (int i = 0; i < npix; i++) begin
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            px(1'b1, p, i == 0, i == npix - 1, 1'b1);
            if (i != npix - 1 && $urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
        end
    endtask

    initial begin
        idle_inputs();
        bus.pixel   = 8'd0;
        bus.rd_addr = 8'd0;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_idle("init");
        read_all("init");

        // Frame A: 10 x bin7 then 3 x bin200, end with last pixel
        px(1, 7, 1, 0, 1);
        repeat (9) px(1, 7, 0, 0, 1);
        px(1, 200, 0, 0, 1);
        px(1, 200, 0, 0, 1);
        px(1, 200, 0, 1, 1);
        finish_frame(7);
        read_all("A");
        wait_idle("A");

        // Frame B: alternating 5/6 with 0/1 gaps, equal totals
        for (int i = 0; i < 100; i++) begin
            px(1, (i % 2 == 0) ? 5 : 6, i == 0, i == 99, 1);
            if (i != 99) gap($urandom_range(0, 1));
        end
        finish_frame(5);
        read_all("B");
        wait_idle("B");

        // Frame C: only bin9; bin7 bank must have been cleared
        px(1, 9, 1, 0, 1);
        px(1, 9, 0, 0, 1);
        px(1, 9, 0, 0, 1);
        px(1, 9, 0, 1, 1);
        finish_frame(5);
        read_all("C");
        wait_idle("C");

        // Drops in IDLE and CLEAR, start during CLEAR becomes pending
        px(1, 33, 0, 0, 0);
        px(1, 34, 0, 0, 0);
        px(1, 3, 1, 0, 1);
        px(1, 3, 0, 0, 1);
        px(1, 3, 0, 1, 1);
        finish_frame(9);
        gap(5);
        px(1, 44, 0, 0, 0);
        px(1, 45, 1, 0, 0);
        px(1, 46, 0, 0, 0);
        check_value("drops after clear", 32'(bus.drop_count), drop_ref);
        wait_idle("auto accum");
        for (int i = 0; i < 6; i++) begin
            px(1, 11, 0, i == 5, 1);
            gap($urandom_range(0, 1));
        end
        finish_frame(3);
        read_all("D");
        wait_idle("D");

        // Randomised frames
        for (int f = 0; f < 3; f++) begin
            random_frame($urandom_range(150, 400));
            finish_frame($urandom_range(0, 15));
            read_all($sformatf("R%0d", f));
            wait_idle("R");
        end

        // Drop counter saturation
        repeat (40) px(1, $urandom_range(0, 255), 0, 0, 0);
        check_value("drop saturate", 32'(bus.drop_count), drop_ref);

        // Bin saturation: CMAX+3 pixels of value 0
        px(1, 0, 1, 0, 1);
        repeat (CMAX + 1) px(1, 0, 0, 0, 1);
        px(1, 0, 0, 1, 1);
        finish_frame(0);
        bus.rd_addr = 8'd0;
        tick();
        check_value("bin0 saturated", 32'(bus.rd_data), CMAX);
        wait_idle("sat");

        // Asynchronous reset in the middle of a frame
        px(1, 1, 1, 0, 1);
        repeat (20) px(1, $urandom_range(0, 3), 0, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("mid-frame reset");
        tick();
        tick();
        rst_n = 1'b1;
        wait_idle("reinit");
        read_all("reinit");

        // Frame after re-init
        px(1, 2, 1, 0, 1);
        px(1, 2, 0, 0, 1);
        px(1, 2, 0, 1, 1);
        finish_frame(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
